// File: rtl/bin_to_bcd_seq_if.sv
// Purpose: start/done handshake and result bus between a requester and bin_to_bcd_seq.
// Latency: wires only, no storage.
// Backpressure: o_busy tells the requester that i_start is ignored until the converter is idle.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
);
  logic                  i_start;
  logic [BIN_W-1:0]      i_bin;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_overflow;
  logic [DIGITS-1:0]     o_blank;

  // Requester side: drives the request, observes status and result.
  modport master (
    output i_start, i_bin,
    input  o_busy, o_done, o_bcd, o_overflow, o_blank
  );

  // Converter side.
  modport slave (
    input  i_start, i_bin,
    output o_busy, o_done, o_bcd, o_overflow, o_blank
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Purpose: sequential binary-to-BCD converter (shift-add-3), saturating to all 9s on overflow.
//          Optional leading-zero blank mask when LEADING_ZERO_BLANK_EN is defined; otherwise o_blank is 0.
// Latency: start accepted in cycle N -> o_done in cycle N+BIN_W+1; o_busy over cycles N+1..N+BIN_W+1.
// Backpressure: i_start is ignored while o_busy is high (not queued); result held between conversions.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;
  logic               w_busy;
  logic               w_done;

  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_overflow;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_work_next;
  logic [BIN_W-1:0]   w_bin_next;
  logic               w_ovf_next;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the busy/done status, both taken straight from the state.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_count == '0) begin
          w_last       = 1'b1;
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Per-digit add-3 correction; each digit is an independent 4-bit add, no carry between digits.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
      end
    end
  end

  // One shift step: binary MSB enters the BCD LSB, BCD MSB leaving the register flags overflow.
  assign w_work_next = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  assign w_bin_next  = {r_bin[BIN_W-2:0], 1'b0};
  assign w_ovf_next  = r_ovf | w_adj[BCD_W-1];

  // Working registers and the held result. The result is loaded on the edge that leaves the
  // final shift, so it is already stable during the single done cycle that follows.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin      <= '0;
      r_work     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bin   <= bus.i_bin;
        r_work  <= '0;
        r_count <= CNT_W'(BIN_W - 1);
        r_ovf   <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        r_bin   <= w_bin_next;
        r_work  <= w_work_next;
        r_count <= r_count - CNT_W'(1);
        r_ovf   <= w_ovf_next;
      end
      if (w_last) begin
        r_bcd      <= w_ovf_next ? {DIGITS{4'h9}} : w_work_next;
        r_overflow <= w_ovf_next;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_blank;
  logic [DIGITS-1:0] r_blank;

  // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin : blank_calc
    logic v_zero_run;
    w_blank    = '0;
    v_zero_run = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (w_work_next[4*d +: 4] != 4'd0) begin
        v_zero_run = 1'b0;
      end
      w_blank[d] = v_zero_run;
    end
    if (w_ovf_next) begin
      w_blank = '0;
    end
  end

  // Blank mask is updated together with the BCD result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blank <= '0;
    end else if (w_last) begin
      r_blank <= w_blank;
    end
  end

  assign bus.o_blank = r_blank;
`else
  assign bus.o_blank = '0;
`endif

  assign bus.o_busy     = w_busy;
  assign bus.o_done     = w_done;
  assign bus.o_bcd      = r_bcd;
  assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Purpose: randomized and directed bench for bin_to_bcd_seq against a decimal reference model.
// Latency: expects done 33 cycles after start acceptance, busy for 33 cycles.
// Backpressure: covers start ignored while busy and start held high for back-to-back runs.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(32), .DIGITS(8)) bus ();

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent run_conv call.
  logic [31:0] c_bcd, c_before;
  logic        c_ovf;
  logic [7:0]  c_blank;
  int          c_lat, c_busy, c_dones;

  // Reference: decimal digits by repeated division, saturating at 10**8.
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    longint unsigned x;
    logic [31:0] r;
    x = v;
    if (x >= 64'd100000000) return 32'h99999999;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] v);
    return (64'(v) >= 64'd100000000);
  endfunction

  // Digit i (i>=1) is a leading zero when the value has at most i decimal digits.
  function automatic logic [7:0] ref_blank(input logic [31:0] v);
    logic [7:0] b;
    longint unsigned p;
    b = '0;
`ifdef LEADING_ZERO_BLANK_EN
    if (64'(v) < 64'd100000000) begin
      p = 1;
      for (int i = 1; i < 8; i++) begin
        p = p * 10;
        b[i] = (64'(v) < p);
      end
    end
`else
    p = 0;
`endif
    return b;
  endfunction

  // Issue one start pulse and watch a fixed window of cycles after acceptance.
  task automatic run_conv(input logic [31:0] v);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_bin   = v;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_bin   = $urandom;
    c_lat = 0; c_busy = 0; c_dones = 0;
    c_bcd = '0; c_ovf = 1'b0; c_blank = '0; c_before = '0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) c_before = bus.o_bcd;
      if (bus.o_busy) c_busy++;
      if (bus.o_done) begin
        c_dones++;
        if (c_dones == 1) begin
          c_lat = k; c_bcd = bus.o_bcd; c_ovf = bus.o_overflow; c_blank = bus.o_blank;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.o_done); else n_pass++;
    n_checks++; if (bus.o_bcd !== 32'h0) $display("FAIL reset_bcd: got %h want 0", bus.o_bcd); else n_pass++;
    n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.o_overflow); else n_pass++;
    n_checks++; if (bus.o_blank !== 8'h0) $display("FAIL reset_blank: got %b want 0", bus.o_blank); else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] vals [5]  = '{32'd0, 32'd12345678, 32'd99999999, 32'd100000000, 32'hFFFFFFFF};
    logic [31:0] exps [5]  = '{32'h0, 32'h12345678, 32'h99999999, 32'h99999999, 32'h99999999};
    logic        ovfs [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_conv(vals[i]);
      n_checks++; if (c_lat !== 33) $display("FAIL dir_latency[%0d]: got %0d want 33", i, c_lat); else n_pass++;
      n_checks++; if (c_busy !== 33) $display("FAIL dir_busy_cycles[%0d]: got %0d want 33", i, c_busy); else n_pass++;
      n_checks++; if (c_dones !== 1) $display("FAIL dir_done_count[%0d]: got %0d want 1", i, c_dones); else n_pass++;
      n_checks++; if (c_bcd !== exps[i]) $display("FAIL dir_bcd[%0d]: got %h want %h", i, c_bcd, exps[i]); else n_pass++;
      n_checks++; if (c_ovf !== ovfs[i]) $display("FAIL dir_ovf[%0d]: got %b want %b", i, c_ovf, ovfs[i]); else n_pass++;
      n_checks++; if (c_blank !== ref_blank(vals[i])) $display("FAIL dir_blank[%0d]: got %b want %b", i, c_blank, ref_blank(vals[i])); else n_pass++;
    end
  endtask

  task automatic test_blank();
    logic [7:0] e305, e0;
`ifdef LEADING_ZERO_BLANK_EN
    e305 = 8'b11111000; e0 = 8'b11111110;
`else
    e305 = 8'b0; e0 = 8'b0;
`endif
    run_conv(32'd305);
    n_checks++; if (c_bcd !== 32'h305) $display("FAIL blank305_bcd: got %h want 305", c_bcd); else n_pass++;
    n_checks++; if (c_blank !== e305) $display("FAIL blank305_mask: got %b want %b", c_blank, e305); else n_pass++;
    run_conv(32'd0);
    n_checks++; if (c_blank !== e0) $display("FAIL blank0_mask: got %b want %b", c_blank, e0); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] v, prev;
    run_conv(32'd7);
    prev = 32'h7;
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       v = $urandom_range(0, 99999999);
        1:       v = $urandom;
        default: v = $urandom_range(0, 999);
      endcase
      run_conv(v);
      n_checks++; if (c_before !== prev) $display("FAIL rnd_hold[%0d]: got %h want %h", i, c_before, prev); else n_pass++;
      n_checks++; if (c_dones !== 1) $display("FAIL rnd_done_count[%0d]: got %0d want 1", i, c_dones); else n_pass++;
      n_checks++; if (c_bcd !== ref_bcd(v)) $display("FAIL rnd_bcd[%0d] bin=%0d: got %h want %h", i, v, c_bcd, ref_bcd(v)); else n_pass++;
      n_checks++; if (c_ovf !== ref_ovf(v)) $display("FAIL rnd_ovf[%0d] bin=%0d: got %b want %b", i, v, c_ovf, ref_ovf(v)); else n_pass++;
      n_checks++; if (c_blank !== ref_blank(v)) $display("FAIL rnd_blank[%0d] bin=%0d: got %b want %b", i, v, c_blank, ref_blank(v)); else n_pass++;
      prev = ref_bcd(v);
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    logic [31:0] got;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_bin = 32'd5;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    dones = 0; got = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 10) begin bus.i_start = 1'b1; bus.i_bin = 32'd7; end
      if (k == 11) bus.i_start = 1'b0;
      if (bus.o_done) begin dones++; if (dones == 1) got = bus.o_bcd; end
    end
    n_checks++; if (dones !== 1) $display("FAIL busy_start_dones: got %0d want 1", dones); else n_pass++;
    n_checks++; if (got !== 32'h5) $display("FAIL busy_start_bcd: got %h want 00000005", got); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_bin = 32'd87654321;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_bcd !== 32'h0) $display("FAIL midrst_bcd: got %h want 0", bus.o_bcd); else n_pass++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    n_checks++; if (dones !== 0) $display("FAIL midrst_no_done: got %0d want 0", dones); else n_pass++;
    run_conv(32'd42);
    n_checks++; if (c_bcd !== 32'h42) $display("FAIL midrst_next_bcd: got %h want 00000042", c_bcd); else n_pass++;
    n_checks++; if (c_dones !== 1) $display("FAIL midrst_next_dones: got %0d want 1", c_dones); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1, v2, b1, b2;
    int dones, t1, t2;
    v1 = $urandom_range(0, 99999999);
    v2 = $urandom;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_bin = v1;
    @(posedge clk);
    #1;
    bus.i_bin = v2;
    dones = 0; t1 = 0; t2 = 0; b1 = '0; b2 = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.o_done) begin
        dones++;
        if (dones == 1) begin t1 = k; b1 = bus.o_bcd; end
        if (dones == 2) begin t2 = k; b2 = bus.o_bcd; bus.i_start = 1'b0; end
      end
    end
    bus.i_start = 1'b0;
    n_checks++; if (dones !== 2) $display("FAIL b2b_dones: got %0d want 2", dones); else n_pass++;
    n_checks++; if (t1 !== 33) $display("FAIL b2b_first_latency: got %0d want 33", t1); else n_pass++;
    n_checks++; if (t2 !== 67) $display("FAIL b2b_second_latency: got %0d want 67", t2); else n_pass++;
    n_checks++; if (b1 !== ref_bcd(v1)) $display("FAIL b2b_first_bcd: got %h want %h", b1, ref_bcd(v1)); else n_pass++;
    n_checks++; if (b2 !== ref_bcd(v2)) $display("FAIL b2b_second_bcd: got %h want %h", b2, ref_bcd(v2)); else n_pass++;
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_bin   = '0;
    rst         = 1'b1;
    test_reset();
    test_directed();
    test_blank();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
